// File: rtl/tcam_lpm.sv
`default_nettype none
// ============================================================================
// Module   : tcam_lpm
// Brief    : TCAM-style longest-prefix-match route table with 2-stage lookup
// Revision : 1.0 - initial release
// ============================================================================
module tcam_lpm #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IFW   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_index,
  input  logic [WIDTH-1:0]         wr_prefix,
  input  logic [WIDTH-1:0]         wr_mask,
  input  logic [IFW-1:0]           wr_if,
  input  logic                     wr_install,
  input  logic                     lk_req,
  input  logic [WIDTH-1:0]         lk_addr,
  output logic                     lk_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_hit,
  output logic [WIDTH-1:0]         rsp_net,
  output logic [IFW-1:0]           rsp_if,
  output logic [7:0]               rsp_prefix_len
);

  localparam int c_IDXW = $clog2(DEPTH);

  function automatic logic [7:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int b = 0; b < WIDTH; b++) n = n + {7'd0, v[b]};
    return n;
  endfunction

  // Route table; only the valid bits need a reset
  logic [WIDTH-1:0] r_prefix [DEPTH];
  logic [WIDTH-1:0] r_mask   [DEPTH];
  logic [IFW-1:0]   r_if     [DEPTH];
  logic [7:0]       r_len    [DEPTH];
  logic [DEPTH-1:0] r_valid;

  // Stage 1 snapshots everything stage 2 needs, so later writes cannot leak in
  logic             r_s1_valid;
  logic [DEPTH-1:0] r_s1_match;
  logic [7:0]       r_s1_len [DEPTH];
  logic [WIDTH-1:0] r_s1_net [DEPTH];
  logic [IFW-1:0]   r_s1_if  [DEPTH];

  logic             w_stall;
  logic             w_accept;
  logic             w_wr_ok;
  logic [DEPTH-1:0] w_wr_sel;
  logic [DEPTH-1:0] w_match;
  logic [WIDTH-1:0] w_wr_net;
  logic [7:0]       w_wr_len;

  logic             w_hit;
  logic [7:0]       w_best_len;
  logic [WIDTH-1:0] w_best_net;
  logic [IFW-1:0]   w_best_if;

  assign w_stall  = rsp_valid & ~rsp_ready;
  assign lk_ready = ~w_stall;
  assign w_accept = lk_req & lk_ready;
  assign w_wr_ok  = 32'(wr_index) < 32'(DEPTH);
  assign w_wr_net = wr_prefix & wr_mask;
  assign w_wr_len = f_popcount(wr_mask);

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_wr_sel[g] = wr_en & w_wr_ok & (wr_index == c_IDXW'(g));
    assign w_match[g]  = r_valid[g] & ((lk_addr & r_mask[g]) == r_prefix[g]);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_sel[i]) begin
        r_prefix[i] <= w_wr_net;
        r_mask[i]   <= wr_mask;
        r_if[i]     <= wr_if;
        r_len[i]    <= w_wr_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_sel[i]) r_valid[i] <= wr_install;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      r_s1_match <= w_match;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_s1_len[i] <= r_len[i];
        r_s1_net[i] <= r_prefix[i];
        r_s1_if[i]  <= r_if[i];
      end
    end
  end

  // Strict '>' keeps the lowest index on equal lengths
  always_comb begin
    w_hit      = 1'b0;
    w_best_len = '0;
    w_best_net = '0;
    w_best_if  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_s1_match[i] && (!w_hit || (r_s1_len[i] > w_best_len))) begin
        w_hit      = 1'b1;
        w_best_len = r_s1_len[i];
        w_best_net = r_s1_net[i];
        w_best_if  = r_s1_if[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_net        <= '0;
      rsp_if         <= '0;
      rsp_prefix_len <= '0;
    end else if (!w_stall) begin
      rsp_valid      <= r_s1_valid;
      rsp_hit        <= r_s1_valid & w_hit;
      rsp_net        <= r_s1_valid ? w_best_net : '0;
      rsp_if         <= r_s1_valid ? w_best_if  : '0;
      rsp_prefix_len <= r_s1_valid ? w_best_len : '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/tcam_lpm.md
TCAM_LPM -- requirements
Module: tcam_lpm

Interface
REQ-001 Parameter WIDTH, default 32: width of the address, prefix and netmask fields.
REQ-002 Parameter DEPTH, default 8: number of route entries, minimum 2.
REQ-003 Parameter IFW, default 4: width of the interface index.
REQ-004 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port wr_en  input  1: table write strobe, sampled each rising edge.
REQ-007 Port wr_index  input  $clog2(DEPTH): entry to write.
REQ-008 Port wr_prefix  input  WIDTH: route prefix.
REQ-009 Port wr_mask  input  WIDTH: netmask, 1 = compared bit.
REQ-010 Port wr_if  input  IFW: egress interface index.
REQ-011 Port wr_install  input  1: 1 = install entry, 0 = invalidate entry.
REQ-012 Port lk_req  input  1: lookup request valid.
REQ-013 Port lk_addr  input  WIDTH: destination address to look up.
REQ-014 Port lk_ready  output  1: lookup accepted when lk_req & lk_ready.
REQ-015 Port rsp_valid  output  1: response valid.
REQ-016 Port rsp_ready  input  1: response consumed when rsp_valid & rsp_ready.
REQ-017 Port rsp_hit  output  1: 1 = matching entry found.
REQ-018 Port rsp_net  output  WIDTH: stored masked prefix of the winning entry.
REQ-019 Port rsp_if  output  IFW: interface index of the winning entry.
REQ-020 Port rsp_prefix_len  output  8: popcount of the winning entry's mask.

Function
REQ-021 On write, the entry SHALL store prefix as wr_prefix & wr_mask, the mask, if index, popcount(wr_mask) and valid = wr_install.
- Entry storage is visible to lookups from the following cycle.
REQ-022 A valid entry SHALL match when (lk_addr & mask) == stored prefix.
- A mask of 0 is a default route and matches every address with length 0.
REQ-023 Non-contiguous masks SHALL be accepted, with length defined as the popcount of the mask.
REQ-024 The lookup SHALL be a 2-stage pipeline.
- Stage 1 registers the per-entry match vector and per-entry lengths.
- Stage 2 registers the longest-prefix winner into the rsp_* outputs.
- Latency from the accepting edge to rsp_valid is 2 cycles.
REQ-025 When equal lengths match, the entry with the lowest index SHALL win.
REQ-026 With no match, the block SHALL drive rsp_hit=0 and rsp_net/rsp_if/rsp_prefix_len=0, with rsp_valid still asserted.
REQ-027 The pipeline SHALL accept one lookup per cycle while rsp_ready=1.
REQ-028 Stall is defined as rsp_valid & ~rsp_ready.
- On stall, lk_ready=0 and both stages and all rsp_* outputs hold unchanged.
- Otherwise lk_ready=1.
REQ-029 A lookup accepted in the same cycle as a write SHALL see the table contents before that write.
REQ-030 Writes SHALL proceed during a stall without altering in-flight match vectors or held responses.
REQ-031 rsp_* outputs SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-032 wr_index >= DEPTH SHALL be ignored, leaving the table unchanged.

Reset
REQ-033 When rst_n=0, the following SHALL clear asynchronously:
- all entry valid bits;
- both pipeline stage valids;
- rsp_valid, rsp_hit, rsp_net, rsp_if and rsp_prefix_len, all to 0.
REQ-034 lk_ready SHALL be 1 during and after reset.
REQ-035 Reset asserted mid-lookup SHALL discard in-flight lookups, which produce no response after release.
REQ-036 Stored prefix, mask and if fields need no reset; an entry is ignored while its valid bit is 0.

Verification
REQ-037 Longest-prefix and default-route test:
- Stimulus: install e0=192.168.0.0/24 if1, e1=192.168.0.0/27 if2, e2=0.0.0.0/0 if3; look up 192.168.0.10, then 192.168.0.60, then 10.0.0.10.
- Required response: if2/27, then if1/24, then if3/0 with rsp_net 0.0.0.0.
REQ-038 Miss, invalidate and tie-break test:
- Stimulus: invalidate e2 and look up 10.0.0.10; then install e3=192.168.0.0/24 if5 and look up 192.168.0.250.
- Required response: rsp_valid=1 with rsp_hit=0; then if1 (e0 beats e3 on equal length).
REQ-039 Back-to-back throughput test:
- Stimulus: 4 consecutive lookups with rsp_ready=1.
- Required response: 4 consecutive rsp_valid cycles starting 2 cycles after the first acceptance, in request order.
REQ-040 Backpressure test:
- Stimulus: hold rsp_ready=0 for 3 cycles with a response pending.
- Required response: lk_ready=0 and rsp_* stable throughout; no lookup lost or duplicated after release.
REQ-041 Write/lookup collision test:
- Stimulus: write e1=192.168.0.0/28 if7 in the same cycle as a lookup of 192.168.0.10; look up the same address again the next cycle.
- Required response: first result if2/27; second result if7/28.
REQ-042 Mid-lookup reset test:
- Stimulus: pulse rst_n low while a lookup is in stage 1.
- Required response: no rsp_valid afterwards; a subsequent lookup of 192.168.0.1 returns rsp_hit=0.
